// File: rtl/wb_arbiter_if.sv
// Wishbone classic bus bundle: one master-to-slave channel with its return path.
// The arbiter takes two slave-side bundles (one per CPU master) and one master-side bundle to the switch.
interface wb_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] sel;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  rdata, ack, err
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output rdata, ack, err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter with cyc-long bus lock, round-robin tie break
// and a per-strobe watchdog that returns err when the switch never acks.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  wb_arbiter_if.slave  m0,
  wb_arbiter_if.slave  m1,
  wb_arbiter_if.master s,
  output logic [1:0]   o_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last;
  logic            last_nxt;
  logic [TO_W-1:0] wd;
  logic [TO_W-1:0] wd_nxt;
  logic            owner_stb;
  logic            timeout_hit;

  // State, round-robin pointer and watchdog registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      last  <= 1'b1;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wd    <= wd_nxt;
    end
  end

  // Next-state: lock while the owner holds cyc, hand over directly when it drops
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    wd_nxt      = '0;
    owner_stb   = 1'b0;
    timeout_hit = 1'b0;

    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = last ? G0 : G1;
        else if (m0.cyc)      state_nxt = G0;
        else if (m1.cyc)      state_nxt = G1;
      end
      G0: begin
        owner_stb = m0.stb;
        if (!m0.cyc) state_nxt = m1.cyc ? G1 : IDLE;
      end
      G1: begin
        owner_stb = m1.stb;
        if (!m1.cyc) state_nxt = m0.cyc ? G0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == G0)      last_nxt = 1'b0;
    else if (state_nxt == G1) last_nxt = 1'b1;

    timeout_hit = owner_stb && !s.ack && (wd == TO_W'(TIMEOUT - 1));

    // Count only uninterrupted wait cycles of the current owner's strobe
    if (state != IDLE && state_nxt == state && owner_stb && !s.ack && !timeout_hit)
      wd_nxt = wd + TO_W'(1);
  end

  // Shared-port mux and return path; ack wins over err because timeout_hit excludes ack
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    s.sel    = '0;
    m0.rdata = s.rdata;
    m1.rdata = s.rdata;
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.err   = 1'b0;
    o_grant  = {state == G1, state == G0};

    case (state)
      G0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
        s.sel   = m0.sel;
        m0.ack  = s.ack;
        m0.err  = timeout_hit;
      end
      G1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.addr  = m1.addr;
        s.wdata = m1.wdata;
        s.sel   = m1.sel;
        m1.ack  = s.ack;
        m1.err  = timeout_hit;
      end
      default: ;
    endcase
  end

endmodule
